// File: rtl/clk_phase_gen.sv
// clk_phase_gen: programmable-ratio clock divider with rise/fall strobes and phase output
// Optional completed-rise counter enabled by defining CLKGEN_PERIOD_CNT_EN.
module clk_phase_gen #(
  parameter int CNT_W        = 4,
  parameter int DEFAULT_DIV  = 4,
  parameter int PERIOD_CNT_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        div_ratio,
  input  logic                    div_load,
  input  logic                    stall,
  output logic                    clk_div,
  output logic                    rise_strb,
  output logic                    fall_strb,
  output logic [CNT_W-1:0]        phase,
  output logic [CNT_W-1:0]        div_active,
  output logic [PERIOD_CNT_W-1:0] period_cnt
);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0] phase_q, phase_d, div_q, div_d, pend_q, pend_d, ratio_san, half;
  logic             pend_vld_q, pend_vld_d, clk_q, clk_d, rise_q, rise_d, fall_q, fall_d, wrap;
  // Next-state: a new ratio only takes effect on the wrap edge, so periods are never cut short
  always_comb begin
    ratio_san  = (div_ratio < CNT_W'(2)) ? CNT_W'(2) : div_ratio;
    wrap       = !stall && (phase_q == div_q - CNT_W'(1));
    div_d      = wrap ? (div_load ? ratio_san : (pend_vld_q ? pend_q : div_q)) : div_q;
    half       = CNT_W'(({1'b0, div_d} + (CNT_W+1)'(1)) >> 1);
    phase_d    = stall ? phase_q : (wrap ? '0 : phase_q + CNT_W'(1));
    clk_d      = stall ? clk_q : (phase_d < half);
    rise_d     = !stall && (phase_d == '0);
    fall_d     = !stall && (phase_d == half);
    pend_vld_d = div_load ? !wrap : (wrap ? 1'b0 : pend_vld_q);
    pend_d     = div_load ? ratio_san : pend_q;
  end
  // Divider state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q    <= DEF_D - CNT_W'(1);
      div_q      <= DEF_D;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end
`ifdef CLKGEN_PERIOD_CNT_EN
  logic [PERIOD_CNT_W-1:0] cnt_q;
  // Count rises in step with the rise strobe; wraps naturally
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else if (rise_d) cnt_q <= cnt_q + PERIOD_CNT_W'(1);
  end
  assign period_cnt = cnt_q;
`else
  assign period_cnt = '0;
`endif
  assign clk_div    = clk_q;
  assign rise_strb  = rise_q;
  assign fall_strb  = fall_q;
  assign phase      = phase_q;
  assign div_active = div_q;
endmodule

// File: tb/tb_clk_phase_gen.sv
// tb_clk_phase_gen: directed and random checks of clk_phase_gen against a behavioural model
module tb_clk_phase_gen;
  localparam int CW = 4;
  localparam int PW = 3;
  logic clock = 0, reset = 1, div_load = 0, stall = 0;
  logic [CW-1:0] div_ratio = '0;
  logic clk_div, rise_strb, fall_strb;
  logic [CW-1:0] phase, div_active;
  logic [PW-1:0] period_cnt;
  int checks = 0, errors = 0;
  int m_phase, m_d, m_pend, m_cnt, m_h;
  bit m_pv;
  logic m_clk, m_rise, m_fall;
  logic exp_clk [8] = '{1, 1, 0, 0, 1, 1, 0, 0};

  clk_phase_gen #(.CNT_W(CW), .DEFAULT_DIV(4), .PERIOD_CNT_W(PW)) dut (
    .clock(clock), .reset(reset), .div_ratio(div_ratio), .div_load(div_load), .stall(stall),
    .clk_div(clk_div), .rise_strb(rise_strb), .fall_strb(fall_strb), .phase(phase),
    .div_active(div_active), .period_cnt(period_cnt));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Period-level model: a period of D cycles is high for the first ceil(D/2) cycles
  task automatic model();
    int s;
    s = (div_ratio < 2) ? 2 : int'(div_ratio);
    if (reset) begin
      m_phase = 3; m_d = 4; m_pv = 0; m_clk = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
    end else if (stall) begin
      m_rise = 0; m_fall = 0;
      if (div_load) begin m_pend = s; m_pv = 1; end
    end else begin
      if (m_phase == m_d - 1) begin
        m_phase = 0;
        if (div_load) m_d = s; else if (m_pv) m_d = m_pend;
        m_pv = 0;
      end else begin
        m_phase++;
        if (div_load) begin m_pend = s; m_pv = 1; end
      end
      m_h = (m_d + 1) / 2;
      m_clk = m_phase < m_h;
      m_rise = m_phase == 0;
      m_fall = m_phase == m_h;
`ifdef CLKGEN_PERIOD_CNT_EN
      if (m_rise) m_cnt = (m_cnt + 1) % (1 << PW);
`endif
    end
  endtask

  task automatic step();
    @(posedge clock);
    model();
    #1;
    chk("clk_div", 32'(clk_div), 32'(m_clk));
    chk("rise_strb", 32'(rise_strb), 32'(m_rise));
    chk("fall_strb", 32'(fall_strb), 32'(m_fall));
    chk("phase", 32'(phase), 32'(m_phase));
    chk("div_active", 32'(div_active), 32'(m_d));
    chk("period_cnt", 32'(period_cnt), 32'(m_cnt));
  endtask

  task automatic goto_phase(input int p);
    for (int k = 0; k < 20 && m_phase != p; k++) step();
    chk("reach_phase", 32'(phase), 32'(p));
  endtask

  initial begin
    reset = 1; step(); step();
    chk("rst_phase", 32'(phase), 3);
    chk("rst_clk", 32'(clk_div), 0);
    chk("rst_div", 32'(div_active), 4);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("d4_clk", 32'(clk_div), 32'(exp_clk[i]));
      chk("d4_rise", 32'(rise_strb), 32'(i == 0 || i == 4));
      chk("d4_fall", 32'(fall_strb), 32'(i == 2 || i == 6));
      chk("d4_phase", 32'(phase), 32'(i % 4));
    end
    goto_phase(1);
    div_ratio = 3; div_load = 1; step(); div_load = 0;
    chk("ld3_old_d", 32'(div_active), 4);
    step();
    chk("ld3_phase3", 32'(phase), 3);
    step();
    chk("ld3_new_d", 32'(div_active), 3);
    chk("ld3_rise", 32'(rise_strb), 1);
    for (int i = 0; i < 6; i++) step();
    goto_phase(1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_phase", 32'(phase), 1);
      chk("stall_clk", 32'(clk_div), 1);
      chk("stall_rise", 32'(rise_strb), 0);
    end
    stall = 0; step();
    chk("unstall_phase", 32'(phase), 2);
    chk("unstall_fall", 32'(fall_strb), 1);
    div_ratio = 0; div_load = 1; step(); div_load = 0;
    goto_phase(0);
    chk("ld0_div", 32'(div_active), 2);
    for (int i = 0; i < 20; i++) step();
    goto_phase(1);
    div_ratio = 7; div_load = 1; step(); div_load = 0;
    reset = 1; step(); reset = 0;
    chk("rst_mid_div", 32'(div_active), 4);
    chk("rst_mid_phase", 32'(phase), 3);
    for (int i = 0; i < 12; i++) step();
    chk("no7_div", 32'(div_active), 4);
    div_ratio = 2; div_load = 1; step(); div_load = 0;
    for (int i = 0; i < 24; i++) step();
    stall = 1; div_ratio = 5; div_load = 1; step(); div_load = 0;
    for (int i = 0; i < 6; i++) step();
    stall = 0;
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 5) == 0);
      div_load = ($urandom_range(0, 7) == 0);
      div_ratio = CW'($urandom_range(0, 15));
      step();
    end
    reset = 0; stall = 0; div_load = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
